// File: rtl/rx_conn_arbiter.sv
// rx_conn_arbiter
//
// Merges four upstream connection lanes into one packet-atomic stream for the
// rx transaction layer. Arbitration is round-robin between packets. Once a
// multi-beat packet starts, its lane stays locked until the last beat. The
// merged stream leaves through a 2-entry output FIFO, so there is one cycle of
// latency and a full beat per cycle of throughput.
//
// Ports
//   clk, reset_n           single rising-edge clock, asynchronous active-low reset
//   lane_data/conn_id/last upstream beat per lane (lane i at slice i)
//   lane_valid/lane_ready  upstream handshake per lane
//   rx_data/connection_id  merged beat and its connection id
//   rx_last/rx_valid       merged end-of-packet marker and beat-present flag
//   rx_ready               downstream accept
//   pkt_cnt                per-lane accepted-packet counters (16 bits per lane)
//
// Configuration
//   RX_ARB_PKT_CNT_EN      when defined, builds the per-lane packet counters.
//                          When undefined, pkt_cnt is tied to zero.

module rx_conn_arbiter #(
  parameter int DATA_W = 128,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [LANES*DATA_W-1:0] lane_data,
  input  logic [LANES*4-1:0]      lane_conn_id,
  input  logic [LANES-1:0]        lane_last,
  input  logic [LANES-1:0]        lane_valid,
  output logic [LANES-1:0]        lane_ready,
  output logic [DATA_W-1:0]       rx_data,
  output logic [3:0]              rx_connection_id,
  output logic                    rx_last,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [LANES*16-1:0]     pkt_cnt
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam int         ENTRY_W   = DATA_W + 5;

  logic [0:0]         state;
  logic [1:0]         grant;
  logic [1:0]         rr_ptr;

  logic [ENTRY_W-1:0] fifo_mem [2];
  logic               wr_idx;
  logic               rd_idx;
  logic [1:0]         fifo_cnt;
  logic               fifo_not_full;

  logic               idle_found;
  logic [1:0]         idle_lane;
  logic [1:0]         cand;
  logic [LANES-1:0]   ready_raw;
  logic [1:0]         sel_lane;
  logic               accept;
  logic               pop;
  logic [ENTRY_W-1:0] push_entry;

  assign fifo_not_full = (fifo_cnt != 2'd2);
  assign rx_valid      = (fifo_cnt != 2'd0);
  assign pop           = rx_valid & rx_ready;

  // Round-robin search starting one past the lane that finished the last
  // packet. The pointer itself is checked last (k = 4 wraps to offset 0).
  always_comb begin
    idle_found = 1'b0;
    idle_lane  = 2'd0;
    cand       = 2'd0;
    for (int k = 1; k <= LANES; k++) begin
      cand = rr_ptr + k[1:0];
      if (!idle_found && lane_valid[cand]) begin
        idle_found = 1'b1;
        idle_lane  = cand;
      end
    end
  end

  // Ready comes only from registered state and lane_valid. rx_ready is not
  // used, so a full FIFO blocks the accept even when a pop is happening.
  always_comb begin
    ready_raw = '0;
    if (fifo_not_full) begin
      if (state == ST_LOCKED) begin
        ready_raw[grant] = 1'b1;
      end else if (idle_found) begin
        ready_raw[idle_lane] = 1'b1;
      end
    end
  end

  // Force ready low while reset is asserted. Without this, an empty FIFO in
  // IDLE would advertise ready during reset.
  assign lane_ready = reset_n ? ready_raw : '0;

  assign sel_lane   = (state == ST_LOCKED) ? grant : idle_lane;
  assign accept     = |(lane_valid & lane_ready);
  assign push_entry = {lane_last[sel_lane],
                       lane_conn_id[int'(sel_lane)*4 +: 4],
                       lane_data[int'(sel_lane)*DATA_W +: DATA_W]};

  // Packet lock. Only the last beat of a packet moves the round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      grant  <= 2'd0;
      rr_ptr <= 2'd3;
    end else if (accept) begin
      if (lane_last[sel_lane]) begin
        state  <= ST_IDLE;
        rr_ptr <= sel_lane;
      end else begin
        state  <= ST_LOCKED;
        grant  <= sel_lane;
      end
    end
  end

  // Two-entry output FIFO. The storage is reset so that rx_* read zero while
  // reset is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_idx   <= 1'b0;
      rd_idx   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (accept) begin
        fifo_mem[wr_idx] <= push_entry;
        wr_idx           <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign {rx_last, rx_connection_id, rx_data} = fifo_mem[rd_idx];

`ifdef RX_ARB_PKT_CNT_EN
  logic [15:0] cnt_q [LANES];

  // Counts accepted last beats per lane. Each counter wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LANES; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_valid[i] && lane_ready[i] && lane_last[i]) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      pkt_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: doc/rx_conn_arbiter.md
RX_CONN_ARBITER -- requirements
Module: rx_conn_arbiter

Interface
REQ-001 Parameter DATA_W, default 128, beat width of every data path.
REQ-002 Parameter LANES, fixed at 4, number of upstream connection lanes.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 lane_data  in  LANES*DATA_W  packed beat per lane; lane i at bits [i*DATA_W +: DATA_W].
REQ-006 lane_conn_id  in  LANES*4  connection id per lane, sampled with each beat.
REQ-007 lane_last  in  LANES  last beat of packet, per lane.
REQ-008 lane_valid  in  LANES  beat present, per lane.
REQ-009 lane_ready  out  LANES  beat accepted on a lane when lane_valid[i] & lane_ready[i] at a clk edge.
REQ-010 rx_data  out  DATA_W  merged beat to the rx transaction layer.
REQ-011 rx_connection_id  out  4  connection id of rx_data.
REQ-012 rx_last  out  1  last beat of merged packet.
REQ-013 rx_valid  out  1  merged beat present.
REQ-014 rx_ready  in  1  downstream accept; transfer on rx_valid & rx_ready.
REQ-015 pkt_cnt  out  LANES*16  per-lane accepted-packet counters (see Configuration).

Function
REQ-016 The block SHALL merge the lanes into one stream, packet-atomic: beats of different packets never interleave on rx_*.
REQ-017 The FSM SHALL have two states, IDLE and LOCKED, plus a 2-bit grant register and a 2-bit round-robin pointer.
REQ-018 In IDLE, with the output buffer not full, the block SHALL grant the first lane with lane_valid set, searching from pointer+1 modulo 4 upward, and accept that lane's beat in the same cycle.
REQ-019 A granted first beat with lane_last=1 SHALL leave the FSM in IDLE; otherwise the FSM SHALL enter LOCKED with grant = that lane.
REQ-020 In LOCKED, only lane_ready[grant] SHALL be asserted, and only while the output buffer is not full; all other lane_ready bits SHALL be 0.
REQ-021 Accepting a beat with lane_last=1 in LOCKED SHALL return the FSM to IDLE.
REQ-022 The pointer SHALL be set to the granted lane on acceptance of every last beat, never otherwise.
REQ-023 lane_ready SHALL depend only on registered state and lane_valid, never combinationally on rx_ready.
REQ-024 Output SHALL be a 2-entry FIFO of {last, conn_id, data}; "not full" means fewer than 2 entries; rx_valid SHALL be 1 exactly when at least 1 entry is held.
REQ-025 Latency SHALL be 1 cycle: a beat accepted at edge N appears on rx_* after edge N, when the buffer was empty.
REQ-026 Throughput SHALL be one beat per cycle with rx_ready held high.
REQ-027 A simultaneous push and pop SHALL keep the occupancy unchanged and SHALL preserve order.
REQ-028 rx_* SHALL hold stable while rx_valid=1 and rx_ready=0.
REQ-029 A lane dropping lane_valid mid-packet SHALL keep the lock; there is no timeout.

Reset
REQ-030 On reset_n=0, the block SHALL asynchronously set: FSM=IDLE, grant=0, pointer=3 (lane 0 wins first), FIFO empty, rx_valid=0, rx_data=0, rx_connection_id=0, rx_last=0, lane_ready=0, pkt_cnt=0.
REQ-031 Reset mid-packet SHALL discard the partial packet and buffered beats; no beat from it SHALL appear after release.

Configuration
REQ-032 Macro RX_ARB_PKT_CNT_EN defined: pkt_cnt[i] SHALL increment by 1 on each accepted lane_last beat of lane i, wrapping 0xFFFF->0x0000.
REQ-033 Macro RX_ARB_PKT_CNT_EN undefined: pkt_cnt SHALL be tied to 0 and no counter flops SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-034 After reset, lanes 0-3 valid together with single-beat packets, rx_ready=1 -> rx_connection_id order follows lanes 0,1,2,3,0 and one beat per cycle after a 1-cycle latency.
REQ-035 Lane 2 sends a 4-beat packet while lane 0 is valid throughout -> 4 lane-2 beats are contiguous on rx_*, last on beat 4, then lane 0 is granted.
REQ-036 rx_ready=0 for 5 cycles during a lane-1 packet -> 2 beats are buffered, lane_ready[1]=0, rx_* stable, and no beat is lost or duplicated after rx_ready=1.
REQ-037 reset_n pulsed low at beat 2 of a 3-beat packet -> outputs are 0 immediately, and the first rx beat after release is from a new packet, granted to lane 0 first.
REQ-038 With RX_ARB_PKT_CNT_EN defined, preload 65535 packets on lane 3, then send 1 more -> pkt_cnt[3] reads 0x0000; with the macro undefined, pkt_cnt stays 0.
